// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// An entry is the decoded-side view of one 32-bit instruction slot.
package ifq_pkg;

  localparam int IFQ_DEPTH = 8;
  localparam int ENTRY_W   = 97;

  typedef struct packed {
    logic        pf;
    logic [63:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  function automatic ifq_entry_t make_entry(input logic        pf,
                                            input logic [63:0] pc,
                                            input logic [31:0] instr);
    ifq_entry_t e;
    e.pf    = pf;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/ifq_ram.sv
// DEPTH x ENTRY_W register array: two write ports for split beats and one
// asynchronous read port feeding the decoder head. Contents are not reset.
module ifq_ram
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we0,
  input  logic [AW-1:0]      waddr0,
  input  logic [ENTRY_W-1:0] wdata0,
  input  logic               we1,
  input  logic [AW-1:0]      waddr1,
  input  logic [ENTRY_W-1:0] wdata1,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  // The two write addresses are always consecutive, so they never collide.
  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[waddr0] = wdata0;
    if (we1) mem_d[waddr1] = wdata1;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: splits 64-bit fetch beats into per-instruction
// entries and hands them to decode one per cycle.
module ifq
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [63:0]            if_data,
  input  logic [63:0]            if_pc,
  input  logic                   if_page_fault,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [31:0]            dec_instr,
  output logic [63:0]            dec_pc,
  output logic                   dec_page_fault,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] PF_INSTR = 32'h0;

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic               push_fire;
  logic               pop_fire;
  logic               push_two;
  logic [1:0]         push_n;
  ifq_entry_t         entry0;
  ifq_entry_t         entry1;
  ifq_entry_t         head;
  logic [ENTRY_W-1:0] rd_data;

  // Handshakes: a transfer happens on a cycle where valid && ready && !flush.
  // if_ready depends only on registered count; dec_valid only on count, so
  // neither side sees a combinational path from the other's inputs.
  assign if_ready  = (count_q <= CNT_W'(DEPTH - 2));
  assign dec_valid = (count_q != '0);

  always_comb begin
    push_fire = if_valid && if_ready && !flush;
    pop_fire  = dec_valid && dec_ready && !flush;
    // A faulting beat yields a single trap entry no matter which half is live.
    push_two  = !if_page_fault && !if_pc[2];
    push_n    = push_fire ? (push_two ? 2'd2 : 2'd1) : 2'd0;

    if (if_page_fault) begin
      entry0 = make_entry(1'b1, if_pc, PF_INSTR);
    end else if (if_pc[2]) begin
      entry0 = make_entry(1'b0, if_pc, if_data[63:32]);
    end else begin
      entry0 = make_entry(1'b0, if_pc, if_data[31:0]);
    end
    entry1 = make_entry(1'b0, if_pc + 64'd4, if_data[63:32]);
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      wp_d    = wp_q + PTR_W'(push_n);
      rp_d    = rp_q + PTR_W'(pop_fire);
      count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  ifq_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we0    (push_fire),
    .waddr0 (wp_q),
    .wdata0 (entry0),
    .we1    (push_fire && push_two),
    .waddr1 (wp_q + PTR_W'(1)),
    .wdata1 (entry1),
    .raddr  (rp_q),
    .rdata  (rd_data)
  );

  assign head           = ifq_entry_t'(rd_data);
  assign dec_instr      = head.instr;
  assign dec_pc         = head.pc;
  assign dec_page_fault = head.pf;
  assign count          = count_q;

endmodule

// File: tb/tb_ifq.sv
// Bench for ifq: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the entry stream.
module tb_ifq;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_data;
  logic [63:0] if_pc;
  logic        if_page_fault;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        dec_page_fault;
  logic [3:0]  count;

  ifq #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_data        (if_data),
    .if_pc          (if_pc),
    .if_page_fault  (if_page_fault),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_page_fault (dec_page_fault),
    .count          (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic check_en = 1'b0;

  // expected entries, oldest first: {pf, pc, instr}
  logic [96:0] exp_q[$];
  logic [96:0] head_e;
  logic        m_ready;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  // reference model: the queue of instructions the decoder should see
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      m_ready = (DEPTH - exp_q.size()) >= 2;
      if (exp_q.size() != 0 && dec_ready) void'(exp_q.pop_front());
      if (if_valid && m_ready) begin
        if (if_page_fault) begin
          exp_q.push_back({1'b1, if_pc, 32'h0});
        end else if (if_pc[2]) begin
          exp_q.push_back({1'b0, if_pc, if_data[63:32]});
        end else begin
          exp_q.push_back({1'b0, if_pc, if_data[31:0]});
          exp_q.push_back({1'b0, if_pc + 64'd4, if_data[63:32]});
        end
      end
    end
    if (!rst_n) check_en <= 1'b1;
  end

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("if_ready", 64'(if_ready), 64'((DEPTH - exp_q.size()) >= 2));
      chk("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        head_e = exp_q[0];
        chk("dec_instr", 64'(dec_instr), 64'(head_e[31:0]));
        chk("dec_pc", dec_pc, head_e[95:32]);
        chk("dec_page_fault", 64'(dec_page_fault), 64'(head_e[96]));
      end
    end
  end

  // driver tasks
  task automatic beat(input logic [63:0] pc, input logic [63:0] data, input logic pf);
    if_valid      = 1'b1;
    if_pc         = pc;
    if_data       = data;
    if_page_fault = pf;
  endtask

  task automatic pop_one();
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
  endtask

  logic       hold;
  logic [1:0] rd_mode;

  initial begin
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; if_data = '0;
    if_pc = '0; if_page_fault = 1'b0; dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);

    // two-entry beat, then drain
    rst_n = 1'b1;
    beat(64'h1000, 64'h00500093_00100013, 1'b0);
    @(negedge clk);
    if_valid = 1'b0;
    chk("b0_count", 64'(count), 64'd2);
    chk("b0_model_size", 64'(exp_q.size()), 64'd2);
    chk("b0_instr", 64'(dec_instr), 64'h00100013);
    chk("b0_pc", dec_pc, 64'h1000);
    dec_ready = 1'b1;
    @(negedge clk);
    chk("b1_instr", 64'(dec_instr), 64'h00500093);
    chk("b1_pc", dec_pc, 64'h1004);
    @(negedge clk);
    dec_ready = 1'b0;
    chk("drained", 64'(dec_valid), 64'd0);

    // upper-half-only beat
    beat(64'h2004, 64'hAAAABBBB_CCCCDDDD, 1'b0);
    @(negedge clk);
    if_valid = 1'b0;
    chk("hi_count", 64'(count), 64'd1);
    chk("hi_pc", dec_pc, 64'h2004);
    chk("hi_instr", 64'(dec_instr), 64'hAAAABBBB);
    pop_one();

    // faulting beat
    beat(64'h3000, 64'h12345678_9ABCDEF0, 1'b1);
    @(negedge clk);
    if_valid = 1'b0;
    chk("pf_count", 64'(count), 64'd1);
    chk("pf_flag", 64'(dec_page_fault), 64'd1);
    chk("pf_pc", dec_pc, 64'h3000);
    chk("pf_instr", 64'(dec_instr), 64'h0);
    pop_one();

    // fill to DEPTH-1: three two-entry beats and one single
    for (int i = 0; i < 3; i++) begin
      beat(64'h4000 + 64'(8 * i), {$urandom, $urandom}, 1'b0);
      @(negedge clk);
    end
    beat(64'h401C, {$urandom, $urandom}, 1'b0);
    @(negedge clk);
    if_valid = 1'b0;
    chk("full_count", 64'(count), 64'd7);
    chk("full_if_ready", 64'(if_ready), 64'd0);
    pop_one();
    chk("pop_count", 64'(count), 64'd6);
    chk("pop_if_ready", 64'(if_ready), 64'd1);
    pop_one();
    chk("c5_count", 64'(count), 64'd5);
    chk("c5_head_pc", dec_pc, 64'h4008);

    // flush with an offered beat and a pending pop
    flush = 1'b1;
    dec_ready = 1'b1;
    beat(64'h6000, {$urandom, $urandom}, 1'b0);
    @(negedge clk);
    flush = 1'b0; if_valid = 1'b0; dec_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_dec_valid", 64'(dec_valid), 64'd0);
    @(negedge clk);
    chk("flush_dropped", 64'(count), 64'd0);

    // random traffic across pointer wrap, flushes and resets
    rd_mode = 2'd0;
    for (int n = 0; n < 4000; n++) begin
      hold = if_valid && !if_ready;
      if ((n % 64) == 0) rd_mode = 2'($urandom_range(0, 2));
      rst_n = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 79) == 0);
      if (!hold) begin
        if_valid      = ($urandom_range(0, 3) != 0);
        if_pc         = {$urandom, $urandom} & ~64'h3;
        if ($urandom_range(0, 15) == 0) if_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        if_data       = {$urandom, $urandom};
        if_page_fault = ($urandom_range(0, 7) == 0);
      end
      case (rd_mode)
        2'd0:    dec_ready = ($urandom_range(0, 3) == 0);
        2'd1:    dec_ready = ($urandom_range(0, 3) != 0);
        default: dec_ready = 1'b1;
      endcase
      @(negedge clk);
    end

    rst_n = 1'b1; flush = 1'b0; if_valid = 1'b0; dec_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("final_empty", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
